// File: rtl/instruction_loader.sv
// Program-load front end: validates a framed image from the UART byte stream,
// writes assembled 32-bit words to instruction RAM and gates the CPU run/reset.
module instruction_loader #(
  parameter int          ADDR_WIDTH     = 16,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  data_access_fault_exception,
  output logic                  instruction_write,
  output logic [31:0]           instruction_in,
  output logic                  cpu_rst,
  output logic                  debug_enable,
  output logic                  load_done,
  output logic                  load_error,
  output logic                  cpu_halted,
  output logic [ADDR_WIDTH-2:0] words_loaded,
  output logic [2:0]            fsm_state
);

  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** (ADDR_WIDTH - 2));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    PAYLOAD = 3'd3,
    CHK     = 3'd4,
    RUN     = 3'd5,
    FAULT   = 3'd6,
    ERROR   = 3'd7
  } state_t;

  state_t          state, state_next;
  logic [15:0]     len;
  logic [7:0]      chk;
  logic [1:0]      idx;
  logic [23:0]     lanes;
  logic [TW-1:0]   to_cnt;
  logic [15:0]     len_full;
  logic            sync_seen, in_frame, expired, len_bad, last_word;

  // byte_valid is a one-cycle strobe with no back-pressure: every strobed
  // byte is consumed in the cycle it is presented.
  assign sync_seen = byte_valid && (byte_data == SYNC_BYTE);
  assign in_frame  = state inside {LEN_LO, LEN_HI, PAYLOAD, CHK};
  assign expired   = in_frame && !byte_valid && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign len_full  = {byte_data, len[7:0]};
  assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > MAX_WORDS);
  assign last_word = ((17'(words_loaded) + 17'd1) == {1'b0, len});
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    cpu_rst      = 1'b1;
    debug_enable = 1'b0;
    case (state)
      IDLE:    if (sync_seen) state_next = LEN_LO;
      LEN_LO:  if (expired) state_next = ERROR;
               else if (byte_valid) state_next = LEN_HI;
      LEN_HI:  if (expired) state_next = ERROR;
               else if (byte_valid) state_next = len_bad ? ERROR : PAYLOAD;
      PAYLOAD: if (expired) state_next = ERROR;
               else if (byte_valid && idx == 2'd3 && last_word) state_next = CHK;
      CHK:     if (expired) state_next = ERROR;
               else if (byte_valid) state_next = (byte_data == chk) ? RUN : ERROR;
      RUN: begin
        cpu_rst      = 1'b0;
        debug_enable = 1'b1;
        // A fault outranks a simultaneous re-arm so the halt is never lost.
        if (data_access_fault_exception) state_next = FAULT;
        else if (sync_seen)              state_next = LEN_LO;
      end
      FAULT: begin
        cpu_rst = 1'b0;
        if (sync_seen) state_next = LEN_LO;
      end
      ERROR:   if (sync_seen) state_next = LEN_LO;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instruction_write <= 1'b0;
      instruction_in    <= '0;
      load_done         <= 1'b0;
      load_error        <= 1'b0;
      cpu_halted        <= 1'b0;
      words_loaded      <= '0;
      len               <= '0;
      chk               <= '0;
      idx               <= '0;
      lanes             <= '0;
      to_cnt            <= '0;
    end else begin
      instruction_write <= 1'b0;
      to_cnt            <= (in_frame && !byte_valid) ? to_cnt + TW'(1) : '0;
      case (state)
        LEN_LO: if (byte_valid) len[7:0] <= byte_data;
        LEN_HI: if (byte_valid) begin
          len[15:8] <= byte_data;
          if (!len_bad) begin
            chk          <= '0;
            idx          <= '0;
            words_loaded <= '0;
            load_error   <= 1'b0;
          end
        end
        PAYLOAD: if (byte_valid && !expired) begin
          chk <= chk ^ byte_data;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            instruction_write <= 1'b1;
            instruction_in    <= {byte_data, lanes};
            words_loaded      <= words_loaded + (ADDR_WIDTH-1)'(1);
          end else begin
            lanes[{idx, 3'b000} +: 8] <= byte_data;
          end
        end
        CHK: if (byte_valid && byte_data == chk) begin
          load_done  <= 1'b1;
          load_error <= 1'b0;
        end
        RUN: if (data_access_fault_exception) cpu_halted <= 1'b1;
        default: ;
      endcase
      if (state_next == ERROR && state != ERROR) begin
        load_error <= 1'b1;
        load_done  <= 1'b0;
      end
      if ((state inside {RUN, FAULT, ERROR}) && state_next == LEN_LO) begin
        cpu_halted <= 1'b0;
        load_done  <= 1'b0;
      end
    end
  end

endmodule
